// File: rtl/button_debounce.sv
// Push-button conditioner: two-flop synchroniser, stable-time debounce FSM,
// debounced level, one-cycle press/release pulses and an 8-bit press counter.
//
// state        | meaning
// -------------+-------------------------------------------------------
// IDLE         | button accepted as released, waiting for a press
// PRESS_WAIT   | press seen, counting stable pressed cycles
// PRESSED      | button accepted as pressed, waiting for a release
// RELEASE_WAIT | release seen, counting stable released cycles
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_WIDTH       = 20,
    parameter bit ACTIVE_HIGH     = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       btn_level,
    output logic       btn_press,
    output logic       btn_release,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    // Raw pin value of an unpressed button; synchroniser resets to it so
    // that no phantom press is seen when reset is released.
    localparam logic RAW_IDLE = ACTIVE_HIGH ? 1'b0 : 1'b1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 s1;
    logic                 s2;
    logic                 p;
    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;

    // Two-flop synchroniser for the asynchronous button pin.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1 <= RAW_IDLE;
            s2 <= RAW_IDLE;
        end else begin
            s1 <= btn_in;
            s2 <= s1;
        end
    end

    // Pressed indication in positive logic regardless of pin polarity.
    assign p = ACTIVE_HIGH ? s2 : ~s2;

    // Debounce FSM; all outputs registered, pulses default low each cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            press_count <= 8'd0;
        end else begin
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            case (state)
                IDLE: begin
                    if (p) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!p) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state       <= PRESSED;
                        btn_level   <= 1'b1;
                        btn_press   <= 1'b1;
                        press_count <= press_count + 8'd1;
                    end else begin
                        cnt <= cnt + CNT_WIDTH'(1);
                    end
                end
                PRESSED: begin
                    if (!p) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (p) begin
                        state <= PRESSED;
                    end else if (cnt == CNT_LAST) begin
                        state       <= IDLE;
                        btn_level   <= 1'b0;
                        btn_release <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES=4, CNT_WIDTH=3.
// dut_a uses an active-high pin, dut_b an active-low pin.
module tb_button_debounce;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_a;
    logic       btn_b;
    logic       level_a, press_a, release_a;
    logic       level_b, press_b, release_b;
    logic [7:0] count_a, count_b;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_cnt;

    always #5 clk = ~clk;

    button_debounce #(.DEBOUNCE_CYCLES(4), .CNT_WIDTH(3), .ACTIVE_HIGH(1'b1)) dut_a (
        .clk(clk), .rst(rst), .btn_in(btn_a),
        .btn_level(level_a), .btn_press(press_a), .btn_release(release_a),
        .press_count(count_a)
    );

    button_debounce #(.DEBOUNCE_CYCLES(4), .CNT_WIDTH(3), .ACTIVE_HIGH(1'b0)) dut_b (
        .clk(clk), .rst(rst), .btn_in(btn_b),
        .btn_level(level_b), .btn_press(press_b), .btn_release(release_b),
        .press_count(count_b)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("a_no_both", {7'd0, press_a & release_a}, 8'd0);
        chk("b_no_both", {7'd0, press_b & release_b}, 8'd0);
    endtask

    // Clean press and release on dut_a, checking the press pulse timing.
    task automatic do_press();
        btn_a = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk("wrap_press", {7'd0, press_a}, (i == 7) ? 8'd1 : 8'd0);
        end
        btn_a = 1'b0;
        for (int i = 1; i <= 8; i++) tick();
        chk("wrap_level", {7'd0, level_a}, 8'd0);
    endtask

    initial begin
        rst   = 1'b0;
        btn_a = 1'b0;
        btn_b = 1'b1;

        // Reset held with the pins toggling.
        for (int i = 0; i < 3; i++) begin
            btn_a = ~btn_a;
            btn_b = ~btn_b;
            tick();
            chk("rst_level_a", {7'd0, level_a}, 8'd0);
            chk("rst_press_a", {7'd0, press_a}, 8'd0);
            chk("rst_rel_a",   {7'd0, release_a}, 8'd0);
            chk("rst_count_a", count_a, 8'd0);
            chk("rst_level_b", {7'd0, level_b}, 8'd0);
            chk("rst_count_b", count_b, 8'd0);
        end
        btn_a = 1'b0;
        btn_b = 1'b1;
        rst   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_rst_level_a", {7'd0, level_a}, 8'd0);
            chk("post_rst_press_a", {7'd0, press_a}, 8'd0);
            chk("post_rst_level_b", {7'd0, level_b}, 8'd0);
            chk("post_rst_press_b", {7'd0, press_b}, 8'd0);
        end

        // Clean press held 20 cycles: pulse only at E7.
        btn_a = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk("clean_press", {7'd0, press_a}, (i == 7) ? 8'd1 : 8'd0);
            chk("clean_level", {7'd0, level_a}, (i >= 7) ? 8'd1 : 8'd0);
            chk("clean_count", count_a, (i >= 7) ? 8'd1 : 8'd0);
            chk("clean_rel", {7'd0, release_a}, 8'd0);
        end

        // Clean release back to IDLE.
        btn_a = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("clean_release", {7'd0, release_a}, (i == 7) ? 8'd1 : 8'd0);
            chk("clean_rlevel", {7'd0, level_a}, (i < 7) ? 8'd1 : 8'd0);
            chk("clean_rcount", count_a, 8'd1);
        end

        // Bounce 1,1,0,1,1,0 then 0: never reaches 4 stable cycles.
        begin
            logic [5:0] pat;
            pat = 6'b011011;
            for (int i = 0; i < 6; i++) begin
                btn_a = pat[i];
                tick();
                chk("bounce_press", {7'd0, press_a}, 8'd0);
                chk("bounce_level", {7'd0, level_a}, 8'd0);
            end
        end
        btn_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("bounce_press0", {7'd0, press_a}, 8'd0);
            chk("bounce_level0", {7'd0, level_a}, 8'd0);
        end
        btn_a = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("bounce_accept", {7'd0, press_a}, (i == 7) ? 8'd1 : 8'd0);
            chk("bounce_alevel", {7'd0, level_a}, (i >= 7) ? 8'd1 : 8'd0);
        end
        chk("bounce_count", count_a, 8'd2);

        // Release with bounce 0,0,1,0 then 0: final 1->0 before edge 4,
        // release accepted at edge 10 of this step.
        begin
            logic [3:0] rpat;
            rpat = 4'b0100;
            for (int i = 1; i <= 12; i++) begin
                btn_a = (i <= 4) ? rpat[i-1] : 1'b0;
                tick();
                chk("rb_release", {7'd0, release_a}, (i == 10) ? 8'd1 : 8'd0);
                chk("rb_level", {7'd0, level_a}, (i < 10) ? 8'd1 : 8'd0);
                chk("rb_press", {7'd0, press_a}, 8'd0);
                chk("rb_count", count_a, 8'd2);
            end
        end

        // 256 presses: counter passes through 255 and wraps to 0.
        exp_cnt = 8'd2;
        for (int n = 0; n < 256; n++) begin
            do_press();
            exp_cnt = exp_cnt + 8'd1;
            chk("wrap_count", count_a, exp_cnt);
        end
        chk("wrap_final", count_a, 8'd2);

        // Reset while in PRESS_WAIT.
        btn_a = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("pw_no_press", {7'd0, press_a}, 8'd0);
        rst   = 1'b0;
        btn_a = 1'b0;
        tick();
        chk("midrst_level", {7'd0, level_a}, 8'd0);
        chk("midrst_press", {7'd0, press_a}, 8'd0);
        chk("midrst_count", count_a, 8'd0);
        chk("midrst_count_b", count_b, 8'd0);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("after_rst_press", {7'd0, press_a}, 8'd0);
            chk("after_rst_level", {7'd0, level_a}, 8'd0);
            chk("after_rst_count", count_a, 8'd0);
        end

        // Active-low pin on dut_b.
        btn_b = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("al_press", {7'd0, press_b}, (i == 7) ? 8'd1 : 8'd0);
            chk("al_level", {7'd0, level_b}, (i >= 7) ? 8'd1 : 8'd0);
        end
        chk("al_count", count_b, 8'd1);
        btn_b = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("al_release", {7'd0, release_b}, (i == 7) ? 8'd1 : 8'd0);
            chk("al_rlevel", {7'd0, level_b}, (i < 7) ? 8'd1 : 8'd0);
        end
        chk("al_rcount", count_b, 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
